imem_program_loader: RTL and testbench

//   Writer side of the instruction-memory interface: receives a program as a byte stream
//   (valid/ready), packs little-endian 32-bit words, and writes them to Instruction_Memory.

---
 rtl/imem_program_loader_if.sv | 31 +++
 rtl/imem_program_loader.sv | 184 ++++++++++++++++++
 tb/tb_imem_program_loader.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_program_loader_if.sv
// Byte-stream input and instruction-memory write bus of the program loader.
// The loader takes the slave modport; the boot host / memory side takes master.
interface imem_program_loader_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
);
  logic [7:0]        byte_data;
  logic              byte_valid;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_data;

  modport master (
    output byte_data,
    output byte_valid,
    input  byte_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_data
  );

  modport slave (
    input  byte_data,
    input  byte_valid,
    output byte_ready,
    output imem_we,
    output imem_addr,
    output imem_data
  );
endinterface

// File: rtl/imem_program_loader.sv
// Boot loader: unpacks a length-prefixed little-endian byte stream into instruction-memory
// writes, holding the CPU in reset until done. IMEM_LOADER_CHECKSUM_EN adds a trailing XOR byte.
module imem_program_loader #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_req_i,
  imem_program_loader_if.slave  bus_if,
  output logic                  cpu_rst_o,
  output logic                  cpu_start_o,
  output logic                  busy_o,
  output logic                  error_o,
  output logic [ADDR_W:0]       words_o
);

  localparam int unsigned Capacity = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    StIdle,
    StLenLo,
    StLenHi,
    StData,
    StChk,
    StDone,
    StError
  } state_e;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e StAfterPayload = StChk;
`else
  localparam state_e StAfterPayload = StDone;
`endif

  state_e              state_q, state_d;
  logic [7:0]          len_lo_q, len_lo_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W:0]     words_q, words_d;
  logic [1:0]          lane_q, lane_d;
  logic [DATA_W-9:0]   buf_q, buf_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]          xor_q, xor_d;
`endif

  logic        byte_ready;
  logic [15:0] len_full;

  assign len_full = {bus_if.byte_data, len_lo_q};

  always_comb begin
    state_d    = state_q;
    len_lo_d   = len_lo_q;
    len_d      = len_q;
    words_d    = words_q;
    lane_d     = lane_q;
    buf_d      = buf_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    xor_d      = xor_q;
`endif
    byte_ready = 1'b0;

    case (state_q)
      StIdle, StDone, StError: begin
        if (load_req_i) begin
          state_d = StLenLo;
          words_d = '0;
          lane_d  = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          xor_d   = '0;
`endif
        end
      end

      StLenLo: begin
        byte_ready = 1'b1;
        if (bus_if.byte_valid) begin
          len_lo_d = bus_if.byte_data;
          state_d  = StLenHi;
        end
      end

      StLenHi: begin
        byte_ready = 1'b1;
        if (bus_if.byte_valid) begin
          if (len_full == 16'd0) begin
            state_d = StAfterPayload;
          end else if (32'(len_full) > Capacity) begin
            state_d = StError;
          end else begin
            len_d   = len_full[ADDR_W:0];
            state_d = StData;
          end
        end
      end

      StData: begin
        // words_q catches up with len_q during the final write cycle; stop accepting then.
        if (words_q == len_q) begin
          state_d = StAfterPayload;
        end else begin
          byte_ready = 1'b1;
          if (bus_if.byte_valid) begin
            lane_d = lane_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_d  = xor_q ^ bus_if.byte_data;
`endif
            unique case (lane_q)
              2'd0: buf_d[7:0]   = bus_if.byte_data;
              2'd1: buf_d[15:8]  = bus_if.byte_data;
              2'd2: buf_d[23:16] = bus_if.byte_data;
              2'd3: begin
                we_d    = 1'b1;
                addr_d  = words_q[ADDR_W-1:0];
                data_d  = {bus_if.byte_data, buf_q};
                words_d = words_q + 1'b1;
              end
            endcase
          end
        end
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      StChk: begin
        byte_ready = 1'b1;
        if (bus_if.byte_valid) begin
          state_d = (bus_if.byte_data == xor_q) ? StDone : StError;
        end
      end
`endif

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      len_lo_q <= '0;
      len_q    <= '0;
      words_q  <= '0;
      lane_q   <= '0;
      buf_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      len_lo_q <= len_lo_d;
      len_q    <= len_d;
      words_q  <= words_d;
      lane_q   <= lane_d;
      buf_q    <= buf_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q    <= xor_d;
`endif
    end
  end

  assign bus_if.byte_ready = byte_ready;
  assign bus_if.imem_we    = we_q;
  assign bus_if.imem_addr  = addr_q;
  assign bus_if.imem_data  = data_q;

  assign cpu_rst_o   = (state_q != StDone);
  assign cpu_start_o = (state_q == StDone);
  assign error_o     = (state_q == StError);
  assign busy_o      = (state_q == StLenLo) || (state_q == StLenHi) ||
                       (state_q == StData)  || (state_q == StChk);
  assign words_o     = words_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Bench for imem_program_loader: directed and random frames checked against a frame-level
// model of expected memory writes. Honours IMEM_LOADER_CHECKSUM_EN like the design.
module tb_imem_program_loader;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            load_req_i;
  logic            cpu_rst_o;
  logic            cpu_start_o;
  logic            busy_o;
  logic            error_o;
  logic [ADDR_W:0] words_o;

  imem_program_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  imem_program_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_req_i  (load_req_i),
    .bus_if      (bus),
    .cpu_rst_o   (cpu_rst_o),
    .cpu_start_o (cpu_start_o),
    .busy_o      (busy_o),
    .error_o     (error_o),
    .words_o     (words_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int last_we_cyc = 0;
  int start_cyc   = 0;
  logic start_prev = 1'b0;

  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [DATA_W-1:0] wr_data_q[$];
  logic [ADDR_W:0]   wr_words_q[$];

  logic [7:0]  frame_q[$];
  logic [31:0] model_q[$];
  int          exp_words;
  bit          exp_err;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Record every write strobe seen; duplicates show up as extra queue entries.
  always @(negedge clk_i) begin
    if (bus.imem_we) begin
      wr_addr_q.push_back(bus.imem_addr);
      wr_data_q.push_back(bus.imem_data);
      wr_words_q.push_back(words_o);
      last_we_cyc <= cyc;
    end
    if (cpu_start_o && !start_prev) start_cyc <= cyc;
    start_prev <= cpu_start_o;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Build the byte stream for a length field n_len from model_q, and derive the outcome.
  task automatic make_frame(input int n_len, input bit chk_good);
    logic [7:0]  x;
    logic [15:0] len16;
    logic [31:0] w;
    len16 = n_len[15:0];
    frame_q.delete();
    frame_q.push_back(len16[7:0]);
    frame_q.push_back(len16[15:8]);
    exp_err   = (n_len > 256);
    exp_words = exp_err ? 0 : n_len;
    x = 8'h00;
    for (int i = 0; i < exp_words; i++) begin
      w = model_q[i];
      for (int b = 0; b < 4; b++) begin
        frame_q.push_back(w[8*b +: 8]);
        x ^= w[8*b +: 8];
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (!exp_err) begin
      frame_q.push_back(chk_good ? x : (x ^ 8'h01));
      exp_err = !chk_good;
    end
`else
    if (!chk_good) x = 8'h00;
`endif
  endtask

  // Called at a negedge; returns at the negedge after the byte has transferred.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int guard;
    bit done;
    bus.byte_valid = 1'b0;
    repeat (gap) @(negedge clk_i);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    guard = 0;
    done  = 1'b0;
    while (!done) begin
      if (bus.byte_ready) begin
        @(posedge clk_i);
        done = 1'b1;
      end else if (guard > 50) begin
        done = 1'b1;
      end
      guard++;
      @(negedge clk_i);
    end
    bus.byte_valid = 1'b0;
    check("byte_accepted_in_time", guard <= 51, 1);
  endtask

  task automatic run_frame(input int gap_min, input int gap_max, input bit hold_req);
    int guard;
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_words_q.delete();
    @(negedge clk_i);
    load_req_i = 1'b1;
    @(negedge clk_i);
    load_req_i = 1'b0;
    check("req_busy", busy_o, 1);
    check("req_words_cleared", words_o, 0);
    check("req_cpu_rst", cpu_rst_o, 1);
    check("req_cpu_start", cpu_start_o, 0);
    for (int i = 0; i < frame_q.size(); i++) begin
      if (hold_req && i == 2) load_req_i = 1'b1;
      send_byte(frame_q[i], $urandom_range(gap_max, gap_min));
    end
    load_req_i = 1'b0;
    guard = 0;
    while (!(cpu_start_o || error_o) && guard < 100) begin
      @(negedge clk_i);
      guard++;
    end
    check("end_reached", guard < 100, 1);
    repeat (2) @(negedge clk_i);
    check("n_writes", wr_addr_q.size(), exp_words);
    for (int i = 0; i < wr_addr_q.size() && i < exp_words; i++) begin
      check("wr_addr", wr_addr_q[i], i);
      check("wr_data", wr_data_q[i], model_q[i]);
      check("wr_words", wr_words_q[i], i + 1);
    end
    check("end_error", error_o, exp_err);
    check("end_cpu_start", cpu_start_o, !exp_err);
    check("end_cpu_rst", cpu_rst_o, exp_err);
    check("end_busy", busy_o, 0);
    check("end_ready", bus.byte_ready, 0);
    check("end_words", words_o, exp_words);
`ifndef IMEM_LOADER_CHECKSUM_EN
    if (exp_words > 0) check("done_latency", start_cyc - last_we_cyc, 1);
`endif
  endtask

  initial begin
    int n;
    rst_i          = 1'b1;
    load_req_i     = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_cpu_rst", cpu_rst_o, 1);
    check("rst_ready", bus.byte_ready, 0);
    check("rst_we", bus.imem_we, 0);
    check("rst_busy", busy_o, 0);
    check("rst_start", cpu_start_o, 0);
    check("rst_error", error_o, 0);
    check("rst_words", words_o, 0);
    check("rst_addr", bus.imem_addr, 0);
    check("rst_data", bus.imem_data, 0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Two-word program, back-to-back bytes, then with 3-cycle stalls between bytes.
    model_q = '{32'h0008_0020, 32'h0010_0113};
    make_frame(2, 1'b1);
    run_frame(0, 0, 1'b0);
    run_frame(3, 3, 1'b0);

    // Oversized length: no writes, straight to error.
    make_frame(257, 1'b1);
    run_frame(0, 1, 1'b0);
    make_frame(16'hFFFF, 1'b1);
    run_frame(0, 0, 1'b0);

    // Empty program and full-capacity program.
    make_frame(0, 1'b1);
    run_frame(0, 1, 1'b0);
    model_q.delete();
    for (int i = 0; i < 256; i++) model_q.push_back($urandom);
    make_frame(256, 1'b1);
    run_frame(0, 0, 1'b0);

    // Reset part-way through the payload aborts the load.
    model_q = '{32'h1111_2222, 32'h3333_4444};
    make_frame(2, 1'b1);
    @(negedge clk_i);
    load_req_i = 1'b1;
    @(negedge clk_i);
    load_req_i = 1'b0;
    for (int i = 0; i < 7; i++) send_byte(frame_q[i], 0);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("midrst_busy", busy_o, 0);
    check("midrst_ready", bus.byte_ready, 0);
    check("midrst_cpu_rst", cpu_rst_o, 1);
    check("midrst_words", words_o, 0);
    check("midrst_we", bus.imem_we, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    model_q = '{$urandom};
    make_frame(1, 1'b1);
    run_frame(0, 1, 1'b0);

    // Random programs with random stalls; odd runs hold load_req_i during the payload.
    for (int t = 0; t < 8; t++) begin
      n = $urandom_range(6, 1);
      model_q.delete();
      for (int i = 0; i < n; i++) model_q.push_back($urandom);
      make_frame(n, 1'b1);
      run_frame(0, 2, t[0]);
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    model_q = '{32'hDDCC_BBAA};
    make_frame(1, 1'b1);
    run_frame(0, 0, 1'b0);
    make_frame(1, 1'b0);
    run_frame(0, 0, 1'b0);
    model_q = '{$urandom, $urandom, $urandom};
    make_frame(3, 1'b0);
    run_frame(0, 2, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
